// File: rtl/arb_rr16.sv
// Round-robin arbiter for 16 requesters: one grant at a time, released on done,
// on request drop, or forcibly after HOLD_MAX cycles, with a dead cycle between grants.
module arb_rr16 #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant_onehot,
  output logic        timeout,
  output logic        dbg_state_o
);

  // Handshake: a requester holds req[i] while it wants the resource; while
  // grant_valid && grant_idx == i it owns it and pulses done (or drops req[i]) to hand back.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t      state_q;
  logic [3:0]  ptr_q;
  logic [3:0]  idx_q;
  logic [7:0]  hold_cnt_q;
  logic        valid_q;
  logic [15:0] onehot_q;
  logic        timeout_q;

  logic        sel_found_d;
  logic [3:0]  sel_idx_d;
  logic        cur_req;
  logic        limit_hit;
  logic        release_now;

  // First set request bit starting at ptr_q and wrapping through 15 -> 0.
  always_comb begin
    logic [3:0] cand;
    cand        = ptr_q;
    sel_found_d = 1'b0;
    sel_idx_d   = ptr_q;
    for (int i = 0; i < 16; i++) begin
      cand = ptr_q + 4'(i);
      if (!sel_found_d && req[cand]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = cand;
      end
    end
  end

  assign cur_req     = req[idx_q];
  assign limit_hit   = (hold_cnt_q == HOLD_LAST);
  assign release_now = done || !cur_req || limit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 4'd0;
      idx_q      <= 4'd0;
      hold_cnt_q <= 8'd0;
      valid_q    <= 1'b0;
      onehot_q   <= 16'h0000;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found_d) begin
            state_q    <= GRANT;
            idx_q      <= sel_idx_d;
            valid_q    <= 1'b1;
            onehot_q   <= 16'h0001 << sel_idx_d;
            hold_cnt_q <= 8'd0;
          end else begin
            valid_q  <= 1'b0;
            onehot_q <= 16'h0000;
          end
        end
        GRANT: begin
          if (release_now) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            onehot_q  <= 16'h0000;
            ptr_q     <= idx_q + 4'd1;
            // Timeout only when the hold limit is the sole reason for release.
            timeout_q <= !done && cur_req;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign grant_valid  = valid_q;
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign timeout      = timeout_q;
  assign dbg_state_o  = (state_q == GRANT);

endmodule

// File: tb/tb_arb_rr16.sv
// Directed bench for arb_rr16: two instances (HOLD_MAX=4 and HOLD_MAX=1) share stimulus,
// a per-cycle compare against a grant/queue-style model, plus literal checkpoints.
module tb_arb_rr16;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;

  logic        gv  [2];
  logic [3:0]  gi  [2];
  logic [15:0] goh [2];
  logic        gto [2];
  logic        dbg [2];

  int n_checks = 0;
  int n_errors = 0;

  arb_rr16 #(.HOLD_MAX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant_valid(gv[0]), .grant_idx(gi[0]), .grant_onehot(goh[0]),
    .timeout(gto[0]), .dbg_state_o(dbg[0])
  );

  arb_rr16 #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant_valid(gv[1]), .grant_idx(gi[1]), .grant_onehot(goh[1]),
    .timeout(gto[1]), .dbg_state_o(dbg[1])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // model: who owns the resource, for how many cycles, and where the search starts next
  bit m_busy [2];
  int m_idx  [2];
  int m_ptr  [2];
  int m_held [2];
  bit m_to   [2];

  function automatic int limit_of(input int m);
    return (m == 0) ? 4 : 1;
  endfunction

  function automatic int first_set(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_idx[m] = 0; m_ptr[m] = 0; m_held[m] = 0; m_to[m] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int m = 0; m < 2; m++) begin
        if (!rst_n) begin
          m_busy[m] = 0; m_idx[m] = 0; m_ptr[m] = 0; m_held[m] = 0; m_to[m] = 0;
        end else begin
          m_to[m] = 0;
          if (!m_busy[m]) begin
            if (req != 16'h0000) begin
              m_busy[m] = 1;
              m_idx[m]  = first_set(req, m_ptr[m]);
              m_held[m] = 1;
            end
          end else if (done || !req[m_idx[m]] || m_held[m] == limit_of(m)) begin
            m_to[m]   = !done && req[m_idx[m]];
            m_busy[m] = 0;
            m_ptr[m]  = (m_idx[m] + 1) % 16;
          end else begin
            m_held[m] = m_held[m] + 1;
          end
        end
      end
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input int m, input string tag, input logic v, input logic [3:0] idx,
                     input logic [15:0] oh, input logic to);
    chk($sformatf("%s.valid%0d", tag, m), 32'(gv[m]), 32'(v));
    chk($sformatf("%s.idx%0d", tag, m), 32'(gi[m]), 32'(idx));
    chk($sformatf("%s.onehot%0d", tag, m), 32'(goh[m]), 32'(oh));
    chk($sformatf("%s.timeout%0d", tag, m), 32'(gto[m]), 32'(to));
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("cmp.valid%0d", m), 32'(gv[m]), 32'(m_busy[m]));
        chk($sformatf("cmp.idx%0d", m), 32'(gi[m]), 32'(m_idx[m]));
        chk($sformatf("cmp.onehot%0d", m), 32'(goh[m]),
            m_busy[m] ? (32'h1 << m_idx[m]) : 32'h0);
        chk($sformatf("cmp.timeout%0d", m), 32'(gto[m]), 32'(m_to[m]));
        chk($sformatf("cmp.state%0d", m), 32'(dbg[m]), 32'(m_busy[m]));
      end
    end
  end

  // driver
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;
    repeat (2) cyc();
    lit(0, "rst", 1'b0, 4'd0, 16'h0000, 1'b0);
    lit(1, "rst", 1'b0, 4'd0, 16'h0000, 1'b0);
    rst_n = 1'b1;

    // round robin with done every grant cycle; done in IDLE must be ignored
    req  = 16'hFFFF;
    done = 1'b1;
    for (int k = 0; k < 17; k++) begin
      cyc();
      lit(0, "rr_grant", 1'b1, 4'(k % 16), 16'h0001 << (k % 16), 1'b0);
      cyc();
      lit(0, "rr_dead", 1'b0, 4'(k % 16), 16'h0000, 1'b0);
    end
    req  = 16'h0000;
    done = 1'b0;
    cyc();

    // single requester, done after three granted cycles
    req = 16'h0020;
    cyc(); lit(0, "single1", 1'b1, 4'd5, 16'h0020, 1'b0);
    cyc(); lit(0, "single2", 1'b1, 4'd5, 16'h0020, 1'b0);
    cyc(); lit(0, "single3", 1'b1, 4'd5, 16'h0020, 1'b0);
    done = 1'b1;
    cyc(); lit(0, "single_rel", 1'b0, 4'd5, 16'h0000, 1'b0);
    done = 1'b0;
    cyc(); lit(0, "single_regrant", 1'b1, 4'd5, 16'h0020, 1'b0);
    req = 16'h0000;
    cyc(); lit(0, "single_drop", 1'b0, 4'd5, 16'h0000, 1'b0);

    // hold limit with HOLD_MAX=4
    req = 16'h0100;
    cyc(); lit(0, "to_grant", 1'b1, 4'd8, 16'h0100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(); lit(0, "to_hold", 1'b1, 4'd8, 16'h0100, 1'b0);
    end
    cyc(); lit(0, "to_pulse", 1'b0, 4'd8, 16'h0000, 1'b1);
    cyc(); lit(0, "to_regrant", 1'b1, 4'd8, 16'h0100, 1'b0);
    req = 16'h0000;
    cyc(); lit(0, "to_drop", 1'b0, 4'd8, 16'h0000, 1'b0);

    // wrap from 14 to 0 then 3; other bits changing during a grant
    req = 16'h4000;
    cyc(); lit(0, "wrap14", 1'b1, 4'd14, 16'h4000, 1'b0);
    req = 16'h0009;
    cyc(); lit(0, "wrap_rel14", 1'b0, 4'd14, 16'h0000, 1'b0);
    cyc(); lit(0, "wrap0", 1'b1, 4'd0, 16'h0001, 1'b0);
    done = 1'b1;
    cyc(); lit(0, "wrap_rel0", 1'b0, 4'd0, 16'h0000, 1'b0);
    done = 1'b0;
    cyc(); lit(0, "wrap3", 1'b1, 4'd3, 16'h0008, 1'b0);
    req = 16'h0FF8;
    cyc(); lit(0, "other_bits", 1'b1, 4'd3, 16'h0008, 1'b0);
    req = 16'h0000;
    cyc(); lit(0, "drop3", 1'b0, 4'd3, 16'h0000, 1'b0);

    // asynchronous reset in the middle of a grant to idx 7
    req = 16'h0080;
    cyc(); lit(0, "pre_rst", 1'b1, 4'd7, 16'h0080, 1'b0);
    #4;
    rst_n = 1'b0;
    #1;
    lit(0, "async_rst", 1'b0, 4'd0, 16'h0000, 1'b0);
    lit(1, "async_rst", 1'b0, 4'd0, 16'h0000, 1'b0);
    req = 16'h0081;
    cyc();
    rst_n = 1'b1;
    cyc();
    lit(0, "post_rst", 1'b1, 4'd0, 16'h0001, 1'b0);
    lit(1, "post_rst", 1'b1, 4'd0, 16'h0001, 1'b0);
    cyc();
    lit(0, "hold4_keep", 1'b1, 4'd0, 16'h0001, 1'b0);
    lit(1, "hold1_to", 1'b0, 4'd0, 16'h0000, 1'b1);
    cyc();
    lit(1, "hold1_next", 1'b1, 4'd7, 16'h0080, 1'b0);
    req = 16'h0000;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arb_rr16.md
ARB_RR16 -- requirements
Module: arb_rr16

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, meaning maximum cycles one grant is held before forced release (legal range 1-255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  16  request vector; bit i = requester i wants the shared resource.
REQ-005 SHALL have port done  input  1  current grantee finished; sampled only in GRANT.
REQ-006 SHALL have port grant_valid  output  1  a grant is active.
REQ-007 SHALL have port grant_idx  output  4  binary index of current grantee.
REQ-008 SHALL have port grant_onehot  output  16  decoded grant, bit grant_idx set when grant_valid, else all zero.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-010 SHALL implement FSM states IDLE and GRANT; all outputs registered.
REQ-011 SHALL keep 4-bit priority pointer ptr; search order ptr, ptr+1, ... ptr+15 modulo 16 (15 wraps to 0).
REQ-012 IDLE, req != 0 at edge: SHALL select first set bit in search order, load grant_idx, set grant_valid=1, grant_onehot=1<<idx, hold_cnt=0, go GRANT.
REQ-013 IDLE, req == 0: SHALL stay IDLE with grant_valid=0, grant_onehot=0, grant_idx unchanged.
REQ-014 Grant latency SHALL be one edge: req sampled at edge k -> grant visible after edge k.
REQ-015 GRANT: SHALL increment 8-bit hold_cnt each edge while grant held.
REQ-016 GRANT release conditions (any at an edge): done=1; req[grant_idx]=0; hold_cnt == HOLD_MAX-1.
REQ-017 On release SHALL clear grant_valid and grant_onehot, set ptr=grant_idx+1 mod 16, go IDLE.
REQ-018 SHALL pulse timeout=1 for exactly the cycle after release only if the release is due solely to hold_cnt limit (done=0 and req[grant_idx]=1).
REQ-019 done and timeout limit simultaneously: SHALL treat as normal release, timeout=0.
REQ-020 SHALL guarantee one dead cycle (grant_valid=0) between consecutive grants, even with req continuously asserted.
REQ-021 Changes on req bits other than grant_idx during GRANT SHALL not affect the active grant.
REQ-022 done asserted in IDLE SHALL be ignored.
REQ-023 With HOLD_MAX=1 each grant SHALL last exactly one cycle.
REQ-024 grant_onehot SHALL never have more than one bit set.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, ptr=0, hold_cnt=0, grant_valid=0, grant_idx=0, grant_onehot=16'h0000, timeout=0.
REQ-026 Reset during GRANT SHALL abort the grant without timeout pulse; first post-reset arbitration starts at ptr=0.

Verification
REQ-027 Single request: req=16'h0020 held, done pulse after 3 granted cycles -> grant_idx=5, grant_onehot=16'h0020 for 3 cycles, one dead cycle, then regrant idx 5.
REQ-028 Round robin: req=16'hFFFF constant, done=1 each GRANT cycle -> grant_idx sequence 0,1,2,...,15,0 with dead cycle between each.
REQ-029 Wrap: after grant to idx 14 released, req=16'h0009 -> next grant idx 0, then idx 3.
REQ-030 Timeout: HOLD_MAX=4, req=16'h0100 held, done=0 -> grant idx 8 for 4 cycles, timeout=1 one cycle after release, next grant idx 8 after dead cycle.
REQ-031 Drop: req[grant_idx] deasserted mid-grant -> grant_valid=0 next edge, timeout=0, ptr=idx+1.
REQ-032 Async reset mid-GRANT (idx 7): rst_n low between edges -> outputs zero immediately; after release with req=16'h0081, grant idx 0.
